// File: rtl/ddr3_pat_loader_pkg.sv
// ddr3_pat_loader_pkg: frame geometry, bus widths and FSM states shared by the pattern loader.
package ddr3_pat_loader_pkg;
  localparam int H_PIXELS = 1920;
  localparam int V_PIXELS = 1080;
  localparam int WORD_W = 256;
  localparam int FRAME_WORDS_DEF = H_PIXELS * V_PIXELS / WORD_W;
  localparam int DDR_AW = 22;
  localparam int MEM_AW = 13;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
endpackage

// File: rtl/ddr3_pat_loader.sv
// ddr3_pat_loader: copies one DMD pattern frame from DDR3 into on-chip memory with credit-limited burst reads.
module ddr3_pat_loader
  import ddr3_pat_loader_pkg::*;
#(
  parameter int FRAME_WORDS = FRAME_WORDS_DEF,
  parameter int BURST_LEN = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                ddr3_emif_clk,
  input  logic                ddr3_emif_rst_n,
  input  logic                start,
  input  logic [DDR_AW-1:0]   base_addr,
  output logic                busy,
  output logic                done,
  input  logic                ddr3_emif_ready,
  output logic                ddr3_emif_read,
  output logic [DDR_AW-1:0]   ddr3_emif_addr,
  output logic [4:0]          ddr3_emif_burst_count,
  output logic                ddr3_emif_write,
  output logic [WORD_W-1:0]   ddr3_emif_write_data,
  output logic [WORD_W/8-1:0] ddr3_emif_byte_enable,
  input  logic [WORD_W-1:0]   ddr3_emif_read_data,
  input  logic                ddr3_emif_rddata_valid,
  output logic                onchip_mem_write,
  output logic [MEM_AW-1:0]   onchip_mem_addr,
  output logic [WORD_W-1:0]   onchip_mem_write_data,
  output logic [WORD_W/8-1:0] onchip_mem_byte_enable,
  output logic                onchip_mem_chip_select,
  output logic                onchip_mem_clken
);
  localparam logic [13:0] FW = 14'(FRAME_WORDS);
  localparam logic [13:0] BL = 14'(BURST_LEN);
  localparam logic [13:0] CREDIT = 14'(MAX_OUTSTANDING * BURST_LEN);
  state_t state, state_n;
  logic [DDR_AW-1:0] base, base_n, addr_n;
  logic [13:0] req_cnt, req_n, wr_cnt, wr_n, req_nx, wr_nx, rem, len;
  logic [4:0] bc_n;
  logic read_n, mwr_n, wr_inc, acc, credit_ok;
  logic [MEM_AW-1:0] maddr_n;
  logic [WORD_W-1:0] mdata_n;
  assign busy = state == S_ISSUE || state == S_DRAIN;
  assign done = state == S_DONE;
  assign ddr3_emif_write = 1'b0;
  assign ddr3_emif_write_data = '0;
  assign ddr3_emif_byte_enable = '1;
  assign onchip_mem_byte_enable = '1;
  assign onchip_mem_chip_select = busy;
  assign onchip_mem_clken = 1'b1;
  // Credit is judged on counts as they will stand after this edge, so issue resumes the cycle a slot frees.
  always_comb begin
    acc = ddr3_emif_read && ddr3_emif_ready;
    wr_inc = busy && ddr3_emif_rddata_valid;
    wr_nx = wr_cnt + {13'd0, wr_inc};
    req_nx = req_cnt + (acc ? {9'd0, ddr3_emif_burst_count} : 14'd0);
    rem = FW - req_nx;
    len = rem > BL ? BL : rem;
    credit_ok = (req_nx - wr_nx) + len <= CREDIT;
    state_n = state;
    base_n = base;
    req_n = req_cnt;
    wr_n = wr_cnt;
    read_n = ddr3_emif_read;
    addr_n = ddr3_emif_addr;
    bc_n = ddr3_emif_burst_count;
    mwr_n = wr_inc;
    maddr_n = wr_inc ? wr_cnt[MEM_AW-1:0] : onchip_mem_addr;
    mdata_n = wr_inc ? ddr3_emif_read_data : onchip_mem_write_data;
    case (state)
      S_IDLE: if (start) begin
        state_n = S_ISSUE;
        base_n = base_addr;
        req_n = '0;
        wr_n = '0;
        read_n = 1'b1;
        addr_n = base_addr;
        bc_n = FW > BL ? BL[4:0] : FW[4:0];
      end
      S_ISSUE: begin
        req_n = req_nx;
        wr_n = wr_nx;
        if (acc || !ddr3_emif_read) begin
          if (req_nx == FW) begin
            state_n = S_DRAIN;
            read_n = 1'b0;
          end else begin
            read_n = credit_ok;
            addr_n = base + {8'd0, req_nx};
            bc_n = len[4:0];
          end
        end
      end
      S_DRAIN: begin
        wr_n = wr_nx;
        state_n = wr_cnt == FW ? S_DONE : S_DRAIN;
      end
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge ddr3_emif_clk or negedge ddr3_emif_rst_n) begin
    if (!ddr3_emif_rst_n) begin
      state <= S_IDLE;
      base <= '0;
      req_cnt <= '0;
      wr_cnt <= '0;
      ddr3_emif_read <= 1'b0;
      ddr3_emif_addr <= '0;
      ddr3_emif_burst_count <= '0;
      onchip_mem_write <= 1'b0;
      onchip_mem_addr <= '0;
      onchip_mem_write_data <= '0;
    end else begin
      state <= state_n;
      base <= base_n;
      req_cnt <= req_n;
      wr_cnt <= wr_n;
      ddr3_emif_read <= read_n;
      ddr3_emif_addr <= addr_n;
      ddr3_emif_burst_count <= bc_n;
      onchip_mem_write <= mwr_n;
      onchip_mem_addr <= maddr_n;
      onchip_mem_write_data <= mdata_n;
    end
  end
endmodule

// File: tb/tb_ddr3_pat_loader.sv
// tb_ddr3_pat_loader: table-driven frame loads against a DDR3 read model, plus credit, reset and start-while-busy sequences.
module tb_ddr3_pat_loader;
  logic clk = 1'b0;
  logic rst_n, start, busy, done, ready, read, wr, valid, mwr, mcs, mclk;
  logic [21:0] base_addr, addr;
  logic [4:0] bc;
  logic [255:0] wdata, rdata, mdata;
  logic [31:0] be, mbe;
  logic [12:0] maddr;
  always #5 clk = ~clk;

  ddr3_pat_loader dut (
    .ddr3_emif_clk(clk), .ddr3_emif_rst_n(rst_n), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .ddr3_emif_ready(ready), .ddr3_emif_read(read),
    .ddr3_emif_addr(addr), .ddr3_emif_burst_count(bc), .ddr3_emif_write(wr),
    .ddr3_emif_write_data(wdata), .ddr3_emif_byte_enable(be), .ddr3_emif_read_data(rdata),
    .ddr3_emif_rddata_valid(valid), .onchip_mem_write(mwr), .onchip_mem_addr(maddr),
    .onchip_mem_write_data(mdata), .onchip_mem_byte_enable(mbe),
    .onchip_mem_chip_select(mcs), .onchip_mem_clken(mclk)
  );

  typedef struct {
    logic [21:0] base;
    bit bp;
    int lat;
    int exp_bursts;
    logic [21:0] exp_second;
    logic [21:0] exp_last_addr;
    int exp_last_len;
  } vec_t;
  typedef struct {
    int t;
    logic [21:0] a;
  } pend_t;

  vec_t vecs[3];
  pend_t q[$];
  int checks = 0, errors = 0;
  int cyc = 0, lat = 10, acc_words, ret_words, wr_idx, n_bursts, n_short, n_done, max_out;
  int first_ret, fifth_cyc, last_wr_cyc, last_len, stray = 0;
  logic [21:0] mbase, last_addr, second_addr;
  bit bp = 0, armed = 0;
  bit prev_read = 0, prev_ready = 0;
  logic [21:0] prev_addr;
  logic [4:0] prev_bc;

  function automatic logic [255:0] word(logic [21:0] a);
    return {8{10'h155, a}};
  endfunction

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic arm(logic [21:0] b);
    mbase = b; acc_words = 0; ret_words = 0; wr_idx = 0; n_bursts = 0; n_short = 0;
    n_done = 0; max_out = 0; first_ret = -1; fifth_cyc = -1; last_addr = 0; last_len = 0;
    second_addr = 0; last_wr_cyc = 0; armed = 1;
  endtask

  // DDR3 read model and on-chip write monitor, evaluated between clock edges.
  initial begin
    ready = 1'b1; valid = 1'b0; rdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mwr) begin
        if (armed) begin
          chk("mem_addr", maddr, wr_idx[12:0]);
          chk("mem_data", mdata, word(22'(mbase + wr_idx)));
          wr_idx++;
          last_wr_cyc = cyc;
        end else stray++;
      end
      if (done && armed) begin
        n_done++;
        chk("done_after_last_write", cyc - last_wr_cyc, 1);
      end
      if (prev_read && !prev_ready && rst_n) begin
        chk("hold_read", read, 1);
        chk("hold_addr", addr, prev_addr);
        chk("hold_bc", bc, prev_bc);
      end
      if (q.size() != 0 && q[0].t <= cyc) begin
        valid = 1'b1; rdata = word(q[0].a); void'(q.pop_front());
        ret_words++;
        if (first_ret < 0) first_ret = cyc;
      end else begin
        valid = 1'b0; rdata = '0;
      end
      ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (read && ready) begin
        if (armed) begin
          chk("burst_addr", addr, 22'(mbase + acc_words));
          chk("outstanding_le_64", (acc_words + int'(bc) - ret_words) <= 64, 1);
          if (acc_words + int'(bc) - ret_words > max_out) max_out = acc_words + int'(bc) - ret_words;
          if (n_bursts == 1) second_addr = addr;
          if (bc != 5'd16) n_short++;
          last_addr = addr; last_len = int'(bc);
          n_bursts++;
          if (n_bursts == 5) fifth_cyc = cyc;
          acc_words += int'(bc);
        end
        for (int i = 0; i < int'(bc); i++) q.push_back('{cyc + lat, 22'(addr + 22'(i))});
      end
      prev_read = read && rst_n; prev_ready = ready; prev_addr = addr; prev_bc = bc;
    end
  end

  task automatic drain();
    for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    chk("stray_writes", stray, 0);
  endtask

  task automatic kick(logic [21:0] b);
    @(negedge clk);
    base_addr = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; base_addr = ~b;
    chk("start_busy", busy, 1);
    chk("start_read", read, 1);
    chk("start_addr", addr, b);
    chk("start_bc", bc, 16);
    chk("start_cs", mcs, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0; armed = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_read", read, 0);
    chk("rst_addr", addr, 0);
    chk("rst_bc", bc, 0);
    chk("rst_mwr", mwr, 0);
    chk("rst_maddr", maddr, 0);
    chk("rst_mdata", mdata, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("late_valid_no_write", stray, 0);
  endtask

  task automatic run(vec_t v);
    bit got = 0;
    drain();
    bp = v.bp; lat = v.lat;
    arm(v.base);
    kick(v.base);
    repeat (48) @(negedge clk);
    base_addr = 22'h2AAAAA; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40000; i++) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
    end
    chk("done_seen", got, 1);
    if (got) begin
      chk("done_busy_low", busy, 0);
      chk("frame_writes", wr_idx, 8100);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_at_done_busy", busy, 0);
      chk("start_at_done_read", read, 0);
      repeat (20) @(negedge clk);
      chk("done_count", n_done, 1);
      chk("bursts", n_bursts, v.exp_bursts);
      chk("short_bursts", n_short, 1);
      chk("second_addr", second_addr, v.exp_second);
      chk("last_addr", last_addr, v.exp_last_addr);
      chk("last_len", last_len, v.exp_last_len);
    end
    armed = 0; bp = 0;
  endtask

  initial begin
    vecs[0] = '{22'h001000, 1'b0, 10, 507, 22'h001010, 22'h002FA0, 4};
    vecs[1] = '{22'h123456, 1'b1, 10, 507, 22'h123466, 22'h1253F6, 4};
    vecs[2] = '{22'h3FFFF0, 1'b0, 3, 507, 22'h000000, 22'h001F90, 4};
    rst_n = 1'b0; start = 1'b0; base_addr = '0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_read", read, 0);
    chk("reset_mwr", mwr, 0);
    chk("tie_write", wr, 0);
    chk("tie_wdata", wdata, 0);
    chk("tie_be", be, 32'hFFFF_FFFF);
    chk("tie_mbe", mbe, 32'hFFFF_FFFF);
    chk("tie_clken", mclk, 1);
    chk("reset_cs", mcs, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) run(vecs[i]);
    // Long data latency: the pipeline fills to its credit limit, then issue tracks returns.
    drain();
    lat = 200;
    arm(22'h200000);
    kick(22'h200000);
    for (int i = 0; i < 5000 && wr_idx < 200; i++) @(negedge clk);
    chk("credit_progress", wr_idx >= 200, 1);
    chk("credit_max_out", max_out, 64);
    chk("credit_resume", fifth_cyc > first_ret && fifth_cyc - first_ret <= 17, 1);
    do_reset();
    // Abort a nominal load at word 3000, then reload the full frame.
    drain();
    lat = 10;
    arm(22'h001000);
    kick(22'h001000);
    for (int i = 0; i < 20000 && wr_idx < 3000; i++) @(negedge clk);
    chk("reach_3000", wr_idx >= 3000, 1);
    do_reset();
    run(vecs[0]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
